// File: rtl/fp32_to_fp16_converter.sv
// FP32 -> FP16 narrowing converter: 3-stage valid/ready pipeline, round-to-nearest-even.
// Define FP16_SUBNORMAL_EN to produce FP16 subnormals; otherwise tiny results flush to signed zero.
module fp32_to_fp16_converter #(
  parameter logic SAT_ON_OVF = 1'b0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
);

  typedef enum logic [2:0] {
    K_ZERO = 3'd0,
    K_NORM = 3'd1,
    K_TINY = 3'd2,
    K_OVF  = 3'd3,
    K_INF  = 3'd4,
    K_NAN  = 3'd5
  } kind_e;

  logic        stall_s;
  logic        s1_valid_q, s1_sign_q;
  kind_e       s1_kind_q, s1_kind_d;
  logic [4:0]  s1_elo_q;
  logic [22:0] s1_frac_q;
  logic signed [8:0] eh_s;

  logic        s2_valid_q, s2_sign_q;
  kind_e       s2_kind_q;
  logic [4:0]  s2_exp_q, s2_exp_d;
  logic [9:0]  s2_mant_q, s2_mant_d;
  logic        s2_g_q, s2_g_d, s2_st_q, s2_st_d, s2_rnd_q, s2_rnd_d;
  logic        s2_unf_q, s2_unf_d, s2_inx_q, s2_inx_d;

  logic        out_valid_q;
  logic [15:0] out_data_q, out_data_d;
  logic        out_ovf_q, out_ovf_d, out_unf_q, out_unf_d, out_inx_q, out_inx_d;
  logic        rnd_up_s, lost_s, ovf_s;
  logic [14:0] rounded_s;

`ifdef FP16_SUBNORMAL_EN
  logic signed [9:0] sh_full_s;
  logic [4:0]  s1_sh_d, s1_sh_q;
  logic [34:0] tiny_shift_s;
`endif

  assign stall_s     = out_valid_q & ~out_ready;
  assign in_ready    = ~stall_s;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ovf     = out_ovf_q;
  assign out_unf     = out_unf_q;
  assign out_inexact = out_inx_q;

  // S1: classify the incoming operand by its rebiased exponent
  always_comb begin
    eh_s      = $signed({1'b0, in_data[30:23]}) - 9'sd112;
    s1_kind_d = K_NORM;
    if (in_data[30:23] == 8'hFF) begin
      if (|in_data[22:0]) begin
        s1_kind_d = K_NAN;
      end else begin
        s1_kind_d = K_INF;
      end
    end else if (in_data[30:23] == 8'h00) begin
      s1_kind_d = K_ZERO;
    end else if (eh_s >= 9'sd31) begin
      s1_kind_d = K_OVF;
    end else if (eh_s >= 9'sd1) begin
      s1_kind_d = K_NORM;
    end else begin
      s1_kind_d = K_TINY;
    end
  end

  // S1 register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_kind_q  <= K_ZERO;
      s1_elo_q   <= 5'h00;
      s1_frac_q  <= 23'h000000;
    end else if (!stall_s) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= in_data[31];
      s1_kind_q  <= s1_kind_d;
      s1_elo_q   <= in_data[27:23];
      s1_frac_q  <= in_data[22:0];
    end
  end

`ifdef FP16_SUBNORMAL_EN
  // Subnormal shift distance, clamped so everything below half an ulp lands in sticky
  always_comb begin
    sh_full_s = 10'sd126 - $signed({2'b00, in_data[30:23]});
    if (sh_full_s > 10'sd25) begin
      s1_sh_d = 5'd25;
    end else begin
      s1_sh_d = sh_full_s[4:0];
    end
  end

  // S1 shift-amount register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_sh_q <= 5'd0;
    end else if (!stall_s) begin
      s1_sh_q <= s1_sh_d;
    end
  end

  // Tiny inputs have a shift of at least 14, so the 10-bit result fits in [34:25]
  assign tiny_shift_s = 35'({1'b1, s1_frac_q, 25'h0000000} >> s1_sh_q);
`endif

  // S2: rebias and align into {exp, mant} plus guard/sticky
  always_comb begin
    s2_exp_d  = 5'h00;
    s2_mant_d = 10'h000;
    s2_g_d    = 1'b0;
    s2_st_d   = 1'b0;
    s2_rnd_d  = 1'b0;
    s2_unf_d  = 1'b0;
    s2_inx_d  = 1'b0;
    case (s1_kind_q)
      K_NAN: begin
        s2_exp_d  = 5'h1F;
        s2_mant_d = 10'h200;
      end
      K_INF: begin
        s2_exp_d = 5'h1F;
      end
      K_ZERO: begin
        s2_unf_d = |s1_frac_q;
        s2_inx_d = |s1_frac_q;
      end
      K_NORM: begin
        // e - 112 taken modulo 32 is exact for the normal range 1..30
        s2_exp_d  = s1_elo_q + 5'd16;
        s2_mant_d = s1_frac_q[22:13];
        s2_g_d    = s1_frac_q[12];
        s2_st_d   = |s1_frac_q[11:0];
        s2_rnd_d  = 1'b1;
      end
      K_TINY: begin
`ifdef FP16_SUBNORMAL_EN
        s2_mant_d = tiny_shift_s[34:25];
        s2_g_d    = tiny_shift_s[24];
        s2_st_d   = |tiny_shift_s[23:0];
        s2_rnd_d  = 1'b1;
`else
        s2_unf_d  = 1'b1;
        s2_inx_d  = 1'b1;
`endif
      end
      default: begin
        s2_exp_d = 5'h00;
      end
    endcase
  end

  // S2 register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_kind_q  <= K_ZERO;
      s2_exp_q   <= 5'h00;
      s2_mant_q  <= 10'h000;
      s2_g_q     <= 1'b0;
      s2_st_q    <= 1'b0;
      s2_rnd_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_inx_q   <= 1'b0;
    end else if (!stall_s) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_kind_q  <= s1_kind_q;
      s2_exp_q   <= s2_exp_d;
      s2_mant_q  <= s2_mant_d;
      s2_g_q     <= s2_g_d;
      s2_st_q    <= s2_st_d;
      s2_rnd_q   <= s2_rnd_d;
      s2_unf_q   <= s2_unf_d;
      s2_inx_q   <= s2_inx_d;
    end
  end

  // S3: RNE round; a mantissa carry ripples into the exponent field through the add
  always_comb begin
    rnd_up_s  = s2_rnd_q & s2_g_q & (s2_st_q | s2_mant_q[0]);
    rounded_s = {s2_exp_q, s2_mant_q} + {14'h0000, rnd_up_s};
    lost_s    = s2_rnd_q & (s2_g_q | s2_st_q);
    ovf_s     = (s2_kind_q == K_OVF) | (s2_rnd_q & (rounded_s[14:10] == 5'h1F));
    out_data_d = {s2_sign_q, rounded_s};
    out_ovf_d  = 1'b0;
    out_unf_d  = s2_unf_q | ((s2_kind_q == K_TINY) & lost_s);
    out_inx_d  = s2_inx_q | lost_s;
    if (ovf_s) begin
      out_data_d = SAT_ON_OVF ? {s2_sign_q, 5'h1E, 10'h3FF} : {s2_sign_q, 5'h1F, 10'h000};
      out_ovf_d  = 1'b1;
      out_unf_d  = 1'b0;
      out_inx_d  = 1'b1;
    end else begin
      out_ovf_d  = 1'b0;
    end
  end

  // Output register; contents only change when a valid result advances
  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_inx_q   <= 1'b0;
    end else if (!stall_s) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= out_data_d;
        out_ovf_q  <= out_ovf_d;
        out_unf_q  <= out_unf_d;
        out_inx_q  <= out_inx_d;
      end
    end
  end

endmodule

// File: doc/fp32_to_fp16_converter.md
Name: fp32_to_fp16_converter

Overview:
- Pipelined converter from IEEE single precision (FP32) back to half precision (FP16).
- Sits downstream of the FP32 accumulator in the floating MAC. It narrows accumulated results back to the 16-bit operand format so they can be reused as FP16 multiplier inputs or written to FP16 storage.
- Three register stages with a valid/ready handshake. Rounding is round-to-nearest-even. Status flags are produced for every result.

Parameters:
- SAT_ON_OVF, 0, 0 = overflow produces signed infinity; 1 = overflow clamps to signed max finite (0x7BFF / 0xFBFF).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  synchronous reset, active low.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  FP32 operand: sign[31], exponent[30:23], fraction[22:0].
- out_valid  output  1  out_data and flags are valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  16  FP16 result: sign[15], exponent[14:10], fraction[9:0].
- out_ovf  output  1  overflow occurred (finite input, result exceeds 65504 after rounding).
- out_unf  output  1  result is tiny (below 2^-14) and inexact.
- out_inexact  output  1  result differs from the input value.

Behaviour:
- Reset, while resetn=0 at a clock edge:
  - All stage valids clear to 0.
  - out_valid=0, out_data=16'h0000, all flags 0.
  - Any in-flight data is discarded.
- Pipeline: S1 unpack/classify, S2 rebias/align, S3 round/pack into the output register. Latency is 3 cycles from accepted input to out_valid when not stalled.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - A transfer occurs when in_valid & in_ready.
  - On stall, every stage holds its contents, so there are no bubbles to collapse.
  - Results emerge in input order with no loss or duplication.
  - Bubbles propagate as invalid stages.
  - out_data and flags stay stable while out_valid=1 and out_ready=0.
- Classification (s=sign, e=exponent, f=fraction), with eh = e - 112 as a signed 9-bit value:
  - e=255, f!=0: output {s,5'h1F,10'h200} (quiet NaN); no flags.
  - e=255, f=0: output {s,5'h1F,10'h000}; no flags.
  - e=0: output {s,15'h0}. If f!=0, unf=1 and inexact=1.
  - 1 <= eh <= 30 (normal path):
    - mantissa m = f[22:13], guard g = f[12], sticky st = |f[11:0].
    - Round up if g & (st | m[0]); inexact = g | st.
    - Rounding carry increments the exponent.
    - If the rounded exponent reaches 31, take the overflow path.
  - eh >= 31: overflow path.
  - eh <= 0: tiny path, controlled by the optional feature.
- Overflow path:
  - Sets out_ovf=1 and out_inexact=1.
  - SAT_ON_OVF=0: output {s,5'h1F,10'h0}. SAT_ON_OVF=1: output {s,5'h1E,10'h3FF}.
- Tiny path with subnormals enabled:
  - sig = {1,f} (24 bits); shift sh = 126 - e, clamped to 25.
  - 10-bit result = sig >> sh, with guard and sticky taken from the shifted-out bits. Same RNE rule as the normal path.
  - Output {s,5'h00,result}. A round carry into bit 10 yields exponent 1 (0x0400) naturally through concatenation.
  - unf = inexact, judged before rounding.
- Arithmetic:
  - All exponent math is signed and wide enough to hold e=1..254 without wrap.
  - No path depends on the sign bit except packing.

Optional Feature:
- Macro: FP16_SUBNORMAL_EN.
- Defined: the tiny path produces FP16 subnormals as specified above (gradual underflow).
- Undefined:
  - Tiny path flushes to {s,15'h0} with unf=1 and inexact=1 for any nonzero input.
  - The S2 right-shifter is not built.
  - Normal, overflow, NaN and inf behaviour is identical in both builds.

Test Plan:
- Basic and boundary values (SAT_ON_OVF=0):
  - 0x3F800000 -> 0x3C00, exactly 3 cycles later, flags 000.
  - 0x477FE000 -> 0x7BFF, flags 000.
  - 0x47800000 -> 0x7C00, ovf=1, inexact=1.
  - 0x477FF000 (65520, rounds up) -> 0x7C00, ovf=1. With SAT_ON_OVF=1 -> 0x7BFF, ovf=1.
- Rounding:
  - 0x3F801000 (tie, lsb even) -> 0x3C00, inexact=1.
  - 0x3F803000 (tie, lsb odd) -> 0x3C02, inexact=1.
  - 0x3F801001 (above tie) -> 0x3C01, inexact=1.
- Specials:
  - 0x7FC00000 -> 0x7E00.
  - 0xFF800000 -> 0xFC00.
  - 0x80000000 -> 0x8000.
  - 0x00000001 -> 0x0000, unf=1, inexact=1.
  - No ovf on any of these.
- Tiny path:
  - With FP16_SUBNORMAL_EN: 0x33800000 -> 0x0001 with unf=0; 0x387FC000 -> 0x03FF exact; 0x387FF000 -> 0x0400, unf=1, inexact=1; 0x33000000 -> 0x0000, unf=1 (tie to even).
  - Without the macro: 0x33800000 -> 0x0000, unf=1, inexact=1.
- Backpressure:
  - Drive 6 back-to-back inputs 0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000.
  - Hold out_ready=0 for 5 cycles mid-stream.
  - Required: in_ready=0 during the stall, out_data held stable, outputs 0x3C00, 0x4000, 0x4200, 0x4400, 0x4500, 0x4600 in order with none lost or duplicated.
- Reset mid-stream: assert resetn=0 for one cycle with 3 results in flight -> out_valid=0 and out_data=0 after that edge; no stale result appears afterwards; the next input emerges 3 cycles after acceptance.
